key_expansion_seq: RTL and testbench

- Iterative AES-128 key schedule. Generates one round key per clock from a 128-bit cipher key and packs all Nr+1 round keys onto a flat bus.
- Sits directly upstream of the round-iterative encrypt core and drives its allKeys input.
- Replaces the purely combinational expansion: area drops to one SubWord (4 S-boxes) plus the key register file.
- Start/busy/done handshake; the encrypt core is held in reset until done is high.

---
 rtl/key_expansion_seq.sv | 134 +++++++++++++
 tb/tb_key_expansion_seq.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/key_expansion_seq.sv
// Iterative AES-128 key schedule: one round key per clock into a flat key bus.
// Optional zeroize input enabled by defining KEYEXP_ZEROIZE_EN.
module key_expansion_seq #(
  parameter int Nk = 4,
  parameter int Nr = 10
) (
  input  logic                    clk,
  input  logic                    reset,
`ifdef KEYEXP_ZEROIZE_EN
  input  logic                    zeroize,
`endif
  input  logic [32*Nk-1:0]        key,
  input  logic                    start,
  output logic                    busy,
  output logic                    done,
  output logic [(Nr+1)*128-1:0]   allKeys
);

  localparam int IW = $clog2(Nr + 1);

  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  typedef enum logic [1:0] {
    IDLE,
    EXPAND,
    DONE
  } state_e;

  state_e          state_q, state_d;
  logic [127:0]    work_q, work_d;
  logic [7:0]      rcon_q, rcon_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [127:0]    slot_q [Nr+1];
  logic [127:0]    slot_d [Nr+1];

  logic [31:0]     rot, sub, t;
  logic [31:0]     w0n, w1n, w2n, w3n;

  // Entry b sits at bit 8*(255-b)+7 of the packed table.
  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX[{~b, 3'b111} -: 8];
  endfunction

  always_comb begin
    rot = {work_q[23:0], work_q[31:24]};
    sub = {sbox(rot[31:24]), sbox(rot[23:16]),
           sbox(rot[15:8]), sbox(rot[7:0])};
    t   = sub ^ {rcon_q, 24'h0};
    w0n = work_q[127:96] ^ t;
    w1n = work_q[95:64] ^ w0n;
    w2n = work_q[63:32] ^ w1n;
    w3n = work_q[31:0] ^ w2n;
  end

  always_comb begin
    state_d = state_q;
    work_d  = work_q;
    rcon_d  = rcon_q;
    idx_d   = idx_q;
    slot_d  = slot_q;
    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          slot_d[0] = key;
          for (int i = 1; i <= Nr; i++) slot_d[i] = '0;
          work_d  = key;
          rcon_d  = 8'h01;
          idx_d   = IW'(1);
          state_d = EXPAND;
        end
      end
      EXPAND: begin
        slot_d[idx_q] = {w0n, w1n, w2n, w3n};
        work_d = {w0n, w1n, w2n, w3n};
        rcon_d = {rcon_q[6:0], 1'b0} ^ (rcon_q[7] ? 8'h1b : 8'h00);
        idx_d  = idx_q + IW'(1);
        if (idx_q == IW'(Nr)) state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
`ifdef KEYEXP_ZEROIZE_EN
    if (zeroize) begin
      for (int i = 0; i <= Nr; i++) slot_d[i] = '0;
      work_d  = '0;
      rcon_d  = '0;
      idx_d   = '0;
      state_d = IDLE;
    end
`endif
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      work_q  <= '0;
      rcon_q  <= 8'h01;
      idx_q   <= '0;
      for (int i = 0; i <= Nr; i++) slot_q[i] <= '0;
    end else begin
      state_q <= state_d;
      work_q  <= work_d;
      rcon_q  <= rcon_d;
      idx_q   <= idx_d;
      for (int i = 0; i <= Nr; i++) slot_q[i] <= slot_d[i];
    end
  end

  assign busy = (state_q == EXPAND);
  assign done = (state_q == DONE);

  always_comb begin
    allKeys = '0;
    for (int k = 0; k <= Nr; k++)
      allKeys[(Nr+1)*128-1-128*k -: 128] = slot_q[k];
  end

endmodule

// File: tb/tb_key_expansion_seq.sv
// Directed bench for key_expansion_seq against FIPS-197 key schedules.
// Zeroize scenarios run only when KEYEXP_ZEROIZE_EN is defined.
module tb_key_expansion_seq;

  localparam int NR = 10;
  localparam int W  = (NR + 1) * 128;

  localparam logic [127:0] K1    = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] K1R1  = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] K1R2  = 128'hf2c295f27a96b9435935807a7359f67f;
  localparam logic [127:0] K1R10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] K2    = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] K2R1  = 128'hd6aa74fdd2af72fadaa678f1d6ab76fe;
  localparam logic [127:0] K2R10 = 128'h13111d7fe3944a17f307a78b4d2b30c5;

  logic           clk = 1'b0;
  logic           reset = 1'b0;
  logic           start = 1'b0;
  logic [127:0]   key = '0;
  logic           busy, done;
  logic [W-1:0]   allKeys;
`ifdef KEYEXP_ZEROIZE_EN
  logic           zeroize = 1'b0;
`endif

  int checks = 0;
  int passed = 0;

  always #5 clk = ~clk;

  key_expansion_seq dut (
    .clk     (clk),
    .reset   (reset),
`ifdef KEYEXP_ZEROIZE_EN
    .zeroize (zeroize),
`endif
    .key     (key),
    .start   (start),
    .busy    (busy),
    .done    (done),
    .allKeys (allKeys)
  );

  function automatic logic [127:0] slot(input int k);
    return allKeys[W-1-128*k -: 128];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    #2;
    checks++;
    if (busy !== 1'b0) $display("FAIL reset_busy got=%b exp=0", busy);
    else passed++;
    checks++;
    if (done !== 1'b0) $display("FAIL reset_done got=%b exp=0", done);
    else passed++;
    checks++;
    if (allKeys !== '0) $display("FAIL reset_keys got nonzero exp=0");
    else passed++;
    reset = 1'b1;
    tick();
    tick();
    checks++;
    if (busy !== 1'b0 || done !== 1'b0)
      $display("FAIL reset_idle got busy=%b done=%b exp=0/0", busy, done);
    else passed++;
  endtask

  task automatic test_expand();
    key = K1;
    start = 1'b1;
    tick();
    start = 1'b0;
    key = '1;
    checks++;
    if (busy !== 1'b1 || done !== 1'b0)
      $display("FAIL e0_flags got busy=%b done=%b exp=1/0", busy, done);
    else passed++;
    checks++;
    if (slot(0) !== K1) $display("FAIL e0_slot0 got=%h exp=%h", slot(0), K1);
    else passed++;
    checks++;
    if (slot(1) !== '0 || slot(10) !== '0)
      $display("FAIL e0_unwritten got=%h/%h exp=0", slot(1), slot(10));
    else passed++;
    for (int i = 1; i <= NR; i++) begin
      tick();
      checks++;
      if (done !== (i == NR) || busy !== (i != NR))
        $display("FAIL e%0d_flags got busy=%b done=%b", i, busy, done);
      else passed++;
      if (i == 1) begin
        checks++;
        if (slot(1) !== K1R1) $display("FAIL e1_rk1 got=%h exp=%h", slot(1), K1R1);
        else passed++;
        checks++;
        if (slot(2) !== '0) $display("FAIL e1_rk2_zero got=%h exp=0", slot(2));
        else passed++;
      end
    end
    checks++;
    if (slot(2) !== K1R2) $display("FAIL k1_rk2 got=%h exp=%h", slot(2), K1R2);
    else passed++;
    checks++;
    if (slot(10) !== K1R10) $display("FAIL k1_rk10 got=%h exp=%h", slot(10), K1R10);
    else passed++;
    checks++;
    if (slot(0) !== K1) $display("FAIL k1_rk0 got=%h exp=%h", slot(0), K1);
    else passed++;
    tick();
    tick();
    checks++;
    if (done !== 1'b1 || slot(10) !== K1R10)
      $display("FAIL done_hold got done=%b rk10=%h", done, slot(10));
    else passed++;
  endtask

  task automatic test_ignore_start();
    int n;
    key = K1;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (4) tick();
    key = K2;
    start = 1'b1;
    tick();
    start = 1'b0;
    key = '0;
    n = 5;
    while (!done && n < 20) begin
      tick();
      n++;
    end
    checks++;
    if (n !== 10) $display("FAIL ign_latency got=%0d exp=10", n);
    else passed++;
    checks++;
    if (slot(10) !== K1R10) $display("FAIL ign_rk10 got=%h exp=%h", slot(10), K1R10);
    else passed++;
    checks++;
    if (slot(0) !== K1 || slot(1) !== K1R1)
      $display("FAIL ign_rk01 got=%h/%h exp=%h/%h", slot(0), slot(1), K1, K1R1);
    else passed++;
  endtask

  task automatic test_restart();
    key = K2;
    start = 1'b1;
    tick();
    start = 1'b0;
    checks++;
    if (done !== 1'b0 || busy !== 1'b1)
      $display("FAIL rs_flags got busy=%b done=%b exp=1/0", busy, done);
    else passed++;
    checks++;
    if (slot(0) !== K2) $display("FAIL rs_rk0 got=%h exp=%h", slot(0), K2);
    else passed++;
    checks++;
    if (slot(1) !== '0 || slot(10) !== '0)
      $display("FAIL rs_clear got=%h/%h exp=0", slot(1), slot(10));
    else passed++;
    repeat (NR) tick();
    checks++;
    if (done !== 1'b1) $display("FAIL rs_done got=%b exp=1", done);
    else passed++;
    checks++;
    if (slot(1) !== K2R1) $display("FAIL k2_rk1 got=%h exp=%h", slot(1), K2R1);
    else passed++;
    checks++;
    if (slot(10) !== K2R10) $display("FAIL k2_rk10 got=%h exp=%h", slot(10), K2R10);
    else passed++;
  endtask

  task automatic test_reset_mid();
    key = K1;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (5) tick();
    #2;
    reset = 1'b0;
    #1;
    checks++;
    if (allKeys !== '0 || busy !== 1'b0 || done !== 1'b0)
      $display("FAIL rmid_async got busy=%b done=%b keys_nz=%b exp=0",
               busy, done, |allKeys);
    else passed++;
    #2;
    reset = 1'b1;
    repeat (3) tick();
    checks++;
    if (allKeys !== '0 || busy !== 1'b0 || done !== 1'b0)
      $display("FAIL rmid_idle got busy=%b done=%b keys_nz=%b exp=0",
               busy, done, |allKeys);
    else passed++;
  endtask

`ifdef KEYEXP_ZEROIZE_EN
  task automatic test_zeroize();
    key = K1;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (NR) tick();
    checks++;
    if (done !== 1'b1) $display("FAIL zz_pre_done got=%b exp=1", done);
    else passed++;
    zeroize = 1'b1;
    tick();
    zeroize = 1'b0;
    checks++;
    if (allKeys !== '0 || done !== 1'b0 || busy !== 1'b0)
      $display("FAIL zz_clear got busy=%b done=%b keys_nz=%b", busy, done, |allKeys);
    else passed++;
    zeroize = 1'b1;
    start = 1'b1;
    tick();
    zeroize = 1'b0;
    start = 1'b0;
    tick();
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || allKeys !== '0)
      $display("FAIL zz_prio got busy=%b done=%b keys_nz=%b", busy, done, |allKeys);
    else passed++;
  endtask
`endif

  initial begin
    test_reset();
    test_expand();
    test_ignore_start();
    test_restart();
    test_reset_mid();
`ifdef KEYEXP_ZEROIZE_EN
    test_zeroize();
`endif
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
